u_game_fcl_fade_ctrl: RTL and testbench
=======================================

// Module: u_game_fcl_fade_ctrl
// PURPOSE
//  Parametrised full-colour LED controller for the rhythm-game top level.
//  - Each judge event shows its colour for a hold period, then fades linearly to off.
//  - Game-over runs a cyclic Red->Yellow->Green animation.
//  - Drives per-channel level buses plus PWM pins for the board FCL.
// PARAMETERS
//  CW       4    colour level width per channel; MAX = 2**CW-1
//  HOLD_MS  300  i_tick count a judge colour is held at full level
//  FADE_MS  20   i_tick count per one-level fade decrement
//  ANIM_MS  500  i_tick count per game-over animation step
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  i_tick       in   1   1 ms strobe, one clk wide
//  i_game_over  in   1   1 = game over (animation), 0 = playing
//  i_judge_vld  in   1   one-clk strobe: i_judge is valid
//  i_judge      in   2   00 none, 01 Miss, 10 Normal, 11 Perfect
//  o_fcl_r/g/b  out  CW  current channel level
//  o_pwm_r/g/b  out  1   PWM drive per channel
//  o_busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset: one clk, asynchronous active-low on rst_n.
//    - state=IDLE; all levels, PWM outputs, o_busy, counters and anim_step = 0.
//  - Colours: Miss {MAX,0,0}; Normal {MAX,MAX,0}; Perfect {0,MAX,0}.
//  - FSM IDLE/HOLD/FADE/ANIM. Levels are registered and update the cycle after the causing event.
//    - Any state, i_game_over=1 -> ANIM, anim_step=0, tick_cnt=0; overrides everything.
//    - ANIM, i_game_over=0 -> IDLE, levels 0 next clk.
//    - IDLE/HOLD/FADE, i_judge_vld & i_judge!=00 -> HOLD.
//      - Loads the colour and clears tick_cnt.
//      - Restarts HOLD/FADE; a newer judge always wins.
//    - i_judge_vld with i_judge=00 is ignored; judges are ignored in ANIM.
//    - HOLD: count i_tick; at count HOLD_MS -> FADE, tick_cnt=0.
//    - FADE: every FADE_MS ticks, each nonzero channel decrements by 1 (saturating).
//      - When all channels reach 0 -> IDLE.
//      - Fade from MAX takes MAX*FADE_MS ticks.
//    - ANIM: every ANIM_MS ticks anim_step 0->1->2->0 (R, Y, G at MAX).
//  - Same-cycle events: a judge strobe coincident with i_tick restarts; that tick is not counted.
//  - tick_cnt is wide enough for max(HOLD_MS, FADE_MS, ANIM_MS) and never wraps; it is compared with >= N-1.
//  - Changing i_game_over mid-fade abandons the fade. No state is retained.
// CONFIGURATION
//  FCL_PWM_EN defined:
//    - Free-running CW-bit pwm_cnt increments every clk.
//    - o_pwm_x = (pwm_cnt < o_fcl_x), registered; duty = level/2**CW.
//    - Level 0 never drives high.
//  FCL_PWM_EN undefined:
//    - No pwm_cnt.
//    - o_pwm_x = (o_fcl_x != 0), registered (on/off only).
//  Level buses and FSM are identical in both builds.
// TESTING  (CW=4, HOLD_MS=3, FADE_MS=2, ANIM_MS=4, i_tick every clk)
//  1. Reset: rst_n=0 mid-HOLD -> all outputs 0 immediately; o_busy=0 after release.
//  2. Perfect strobe:
//     - next clk {0,F,0} for 3 ticks;
//     - then g = E, D, ..., 0, stepping every 2 ticks;
//     - IDLE after 30 fade ticks; o_busy falls.
//  3. Miss at fade level 7, then Normal strobe -> {F,F,0} next clk, HOLD restarts at 0.
//  4. i_game_over=1 during FADE:
//     - {F,0,0} next clk, {F,F,0} after 4 ticks, {0,F,0} after 8, {F,0,0} after 12;
//     - a judge strobe has no effect; deassert -> 0 next clk.
//  5. Strobe with i_judge=00 in IDLE -> stays IDLE, outputs 0.
//  6. FCL_PWM_EN build, level 4: o_pwm high exactly 4 of every 16 clk.
//     Non-PWM build: o_pwm constant 1.

Source files
------------

// File: rtl/u_game_fcl_fade_ctrl.sv
// Full-colour LED controller: judge colour hold + linear fade, game-over R/Y/G animation.
// Define FCL_PWM_EN for counter-based PWM duty; otherwise PWM pins are on/off only.
module u_game_fcl_fade_ctrl #(
  parameter int CW      = 4,
  parameter int HOLD_MS = 300,
  parameter int FADE_MS = 20,
  parameter int ANIM_MS = 500
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_tick,
  input  logic          i_game_over,
  input  logic          i_judge_vld,
  input  logic [1:0]    i_judge,
  output logic [CW-1:0] o_fcl_r,
  output logic [CW-1:0] o_fcl_g,
  output logic [CW-1:0] o_fcl_b,
  output logic          o_pwm_r,
  output logic          o_pwm_g,
  output logic          o_pwm_b,
  output logic          o_busy
);

  localparam logic [CW-1:0] MAX  = '1;
  localparam logic [CW-1:0] ZERO = '0;
  localparam int MAXN  = (HOLD_MS > FADE_MS) ? ((HOLD_MS > ANIM_MS) ? HOLD_MS : ANIM_MS)
                                             : ((FADE_MS > ANIM_MS) ? FADE_MS : ANIM_MS);
  // Counter only ever holds 0..N-1, so clog2(N) bits never wrap.
  localparam int CNT_W = (MAXN < 2) ? 1 : $clog2(MAXN);

  typedef enum logic [1:0] {IDLE, HOLD, FADE, ANIM} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step_q, step_d;
  logic [CW-1:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic             pwm_r_q, pwm_r_d, pwm_g_q, pwm_g_d, pwm_b_q, pwm_b_d;

  logic hold_done, fade_done, anim_done;
  assign hold_done = cnt_q >= CNT_W'(HOLD_MS - 1);
  assign fade_done = cnt_q >= CNT_W'(FADE_MS - 1);
  assign anim_done = cnt_q >= CNT_W'(ANIM_MS - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    if (i_game_over) begin
      if (state_q != ANIM) begin
        state_d = ANIM;
        cnt_d   = '0;
        step_d  = 2'd0;
      end else if (i_tick) begin
        if (anim_done) begin
          cnt_d  = '0;
          step_d = (step_q == 2'd2) ? 2'd0 : step_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      case (step_d)
        2'd0:    begin r_d = MAX;  g_d = ZERO; b_d = ZERO; end
        2'd1:    begin r_d = MAX;  g_d = MAX;  b_d = ZERO; end
        default: begin r_d = ZERO; g_d = MAX;  b_d = ZERO; end
      endcase
    end else if (state_q == ANIM) begin
      state_d = IDLE;
      cnt_d   = '0;
      step_d  = 2'd0;
      r_d     = ZERO;
      g_d     = ZERO;
      b_d     = ZERO;
    end else if (i_judge_vld && i_judge != 2'b00) begin
      // A coincident tick is deliberately dropped: the new judge starts from zero.
      state_d = HOLD;
      cnt_d   = '0;
      case (i_judge)
        2'b01:   begin r_d = MAX;  g_d = ZERO; b_d = ZERO; end
        2'b10:   begin r_d = MAX;  g_d = MAX;  b_d = ZERO; end
        default: begin r_d = ZERO; g_d = MAX;  b_d = ZERO; end
      endcase
    end else begin
      case (state_q)
        HOLD: if (i_tick) begin
          if (hold_done) begin
            state_d = FADE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FADE: if (i_tick) begin
          if (fade_done) begin
            cnt_d = '0;
            r_d   = (r_q != ZERO) ? r_q - 1'b1 : ZERO;
            g_d   = (g_q != ZERO) ? g_q - 1'b1 : ZERO;
            b_d   = (b_q != ZERO) ? b_q - 1'b1 : ZERO;
            if (r_d == ZERO && g_d == ZERO && b_d == ZERO) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FCL_PWM_EN
  logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pwm_r_d   = pwm_cnt_q < r_q;
    pwm_g_d   = pwm_cnt_q < g_q;
    pwm_b_d   = pwm_cnt_q < b_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= '0;
    else        pwm_cnt_q <= pwm_cnt_d;
  end
`else
  always_comb begin
    pwm_r_d = r_q != ZERO;
    pwm_g_d = g_q != ZERO;
    pwm_b_d = b_q != ZERO;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 2'd0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      pwm_r_q <= 1'b0;
      pwm_g_q <= 1'b0;
      pwm_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      pwm_r_q <= pwm_r_d;
      pwm_g_q <= pwm_g_d;
      pwm_b_q <= pwm_b_d;
    end
  end

  assign o_fcl_r = r_q;
  assign o_fcl_g = g_q;
  assign o_fcl_b = b_q;
  assign o_pwm_r = pwm_r_q;
  assign o_pwm_g = pwm_g_q;
  assign o_pwm_b = pwm_b_q;
  assign o_busy  = state_q != IDLE;

endmodule

// File: tb/tb_u_game_fcl_fade_ctrl.sv
// Directed bench for u_game_fcl_fade_ctrl with CW=4, HOLD=3, FADE=2, ANIM=4, tick every clk.
module tb_u_game_fcl_fade_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_tick, i_game_over, i_judge_vld;
  logic [1:0] i_judge;
  logic [3:0] o_fcl_r, o_fcl_g, o_fcl_b;
  logic       o_pwm_r, o_pwm_g, o_pwm_b, o_busy;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  u_game_fcl_fade_ctrl #(.CW(4), .HOLD_MS(3), .FADE_MS(2), .ANIM_MS(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_game_over(i_game_over),
    .i_judge_vld(i_judge_vld), .i_judge(i_judge),
    .o_fcl_r(o_fcl_r), .o_fcl_g(o_fcl_g), .o_fcl_b(o_fcl_b),
    .o_pwm_r(o_pwm_r), .o_pwm_g(o_pwm_g), .o_pwm_b(o_pwm_b), .o_busy(o_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] j);
    i_judge_vld = 1'b1;
    i_judge     = j;
    step();
    i_judge_vld = 1'b0;
    i_judge     = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_tick = 1'b0; i_game_over = 1'b0; i_judge_vld = 1'b0; i_judge = 2'b00;
    #3;
    n_chk++;
    if ({o_fcl_r, o_fcl_g, o_fcl_b, o_pwm_r, o_pwm_g, o_pwm_b, o_busy} !== 15'd0) begin
      n_fail++; $display("FAIL reset_state got=%h exp=0",
        {o_fcl_r, o_fcl_g, o_fcl_b, o_pwm_r, o_pwm_g, o_pwm_b, o_busy});
    end
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    step();
    n_chk++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    i_tick = 1'b1;
    strobe(2'b01);
    step();
    n_chk++;
    if ({o_fcl_r, o_fcl_g, o_fcl_b, o_busy} !== {12'hF00, 1'b1}) begin
      n_fail++; $display("FAIL reset_prehold got=%h/%b exp=f00/1", {o_fcl_r, o_fcl_g, o_fcl_b}, o_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_fcl_r, o_fcl_g, o_fcl_b, o_pwm_r, o_pwm_g, o_pwm_b, o_busy} !== 15'd0) begin
      n_fail++; $display("FAIL reset_async got=%h exp=0",
        {o_fcl_r, o_fcl_g, o_fcl_b, o_pwm_r, o_pwm_g, o_pwm_b, o_busy});
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    n_chk++;
    if ({o_fcl_r, o_fcl_g, o_fcl_b, o_busy} !== 13'd0) begin
      n_fail++; $display("FAIL reset_release got=%h/%b exp=0/0", {o_fcl_r, o_fcl_g, o_fcl_b}, o_busy);
    end
  endtask

  task automatic test_perfect();
    int eg;
    strobe(2'b11);
    n_chk++;
    if ({o_fcl_r, o_fcl_g, o_fcl_b, o_busy} !== {12'h0F0, 1'b1}) begin
      n_fail++; $display("FAIL perfect_load got=%h/%b exp=0f0/1", {o_fcl_r, o_fcl_g, o_fcl_b}, o_busy);
    end
    for (int n = 1; n <= 34; n++) begin
      step();
      eg = (n <= 4) ? 15 : ((n >= 33) ? 0 : 15 - (n - 3) / 2);
      n_chk++;
      if ({o_fcl_r, o_fcl_g, o_fcl_b, o_busy} !== {4'h0, 4'(eg), 4'h0, (n < 33)}) begin
        n_fail++; $display("FAIL perfect_fade n=%0d got=%h/%b exp=0%h0/%b",
          n, {o_fcl_r, o_fcl_g, o_fcl_b}, o_busy, 4'(eg), (n < 33));
      end
    end
  endtask

  task automatic test_newer_judge();
    logic [3:0] e;
    strobe(2'b01);
    repeat (19) step();
    n_chk++;
    if ({o_fcl_r, o_fcl_g, o_fcl_b} !== 12'h700) begin
      n_fail++; $display("FAIL miss_at7 got=%h exp=700", {o_fcl_r, o_fcl_g, o_fcl_b});
    end
    strobe(2'b10);
    n_chk++;
    if ({o_fcl_r, o_fcl_g, o_fcl_b} !== 12'hFF0) begin
      n_fail++; $display("FAIL normal_restart got=%h exp=ff0", {o_fcl_r, o_fcl_g, o_fcl_b});
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      e = (k <= 4) ? 4'hF : 4'hE;
      n_chk++;
      if ({o_fcl_r, o_fcl_g, o_fcl_b} !== {e, e, 4'h0}) begin
        n_fail++; $display("FAIL normal_hold k=%0d got=%h exp=%h%h0", k, {o_fcl_r, o_fcl_g, o_fcl_b}, e, e);
      end
    end
    repeat (40) step();
    n_chk++;
    if ({o_fcl_r, o_fcl_g, o_fcl_b, o_busy} !== 13'd0) begin
      n_fail++; $display("FAIL normal_done got=%h/%b exp=0/0", {o_fcl_r, o_fcl_g, o_fcl_b}, o_busy);
    end
  endtask

  task automatic test_game_over();
    logic [11:0] exp_c [3];
    exp_c[0] = 12'hF00; exp_c[1] = 12'hFF0; exp_c[2] = 12'h0F0;
    strobe(2'b11);
    repeat (10) step();
    n_chk++;
    if (o_fcl_g !== 4'hC) begin n_fail++; $display("FAIL go_prefade got=%h exp=c", o_fcl_g); end
    i_game_over = 1'b1;
    step();
    n_chk++;
    if ({o_fcl_r, o_fcl_g, o_fcl_b, o_busy} !== {12'hF00, 1'b1}) begin
      n_fail++; $display("FAIL go_enter got=%h/%b exp=f00/1", {o_fcl_r, o_fcl_g, o_fcl_b}, o_busy);
    end
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) strobe(2'b11);
      else step();
      n_chk++;
      if ({o_fcl_r, o_fcl_g, o_fcl_b} !== exp_c[(k / 4) % 3]) begin
        n_fail++; $display("FAIL go_anim k=%0d got=%h exp=%h", k, {o_fcl_r, o_fcl_g, o_fcl_b}, exp_c[(k / 4) % 3]);
      end
    end
    i_game_over = 1'b0;
    step();
    n_chk++;
    if ({o_fcl_r, o_fcl_g, o_fcl_b, o_busy} !== 13'd0) begin
      n_fail++; $display("FAIL go_exit got=%h/%b exp=0/0", {o_fcl_r, o_fcl_g, o_fcl_b}, o_busy);
    end
  endtask

  task automatic test_null_judge();
    strobe(2'b00);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({o_fcl_r, o_fcl_g, o_fcl_b, o_busy} !== 13'd0) begin
        n_fail++; $display("FAIL null_judge k=%0d got=%h/%b exp=0/0", k, {o_fcl_r, o_fcl_g, o_fcl_b}, o_busy);
      end
      step();
    end
  endtask

  task automatic test_pwm();
    int cr, cg, er;
    cr = 0; cg = 0;
    strobe(2'b01);
    repeat (25) step();
    i_tick = 1'b0;
    n_chk++;
    if (o_fcl_r !== 4'h4) begin n_fail++; $display("FAIL pwm_level got=%h exp=4", o_fcl_r); end
    repeat (2) step();
    for (int k = 0; k < 32; k++) begin
      cr += int'(o_pwm_r);
      cg += int'(o_pwm_g);
      step();
    end
`ifdef FCL_PWM_EN
    er = 8;
`else
    er = 32;
`endif
    n_chk++;
    if (cr !== er) begin n_fail++; $display("FAIL pwm_r_high got=%0d exp=%0d", cr, er); end
    n_chk++;
    if (cg !== 0) begin n_fail++; $display("FAIL pwm_g_high got=%0d exp=0", cg); end
    n_chk++;
    if (o_fcl_r !== 4'h4) begin n_fail++; $display("FAIL pwm_frozen got=%h exp=4", o_fcl_r); end
    i_tick = 1'b1;
    repeat (20) step();
    n_chk++;
    if ({o_busy, o_pwm_r} !== 2'b00) begin
      n_fail++; $display("FAIL pwm_end got=%b exp=00", {o_busy, o_pwm_r});
    end
  endtask

  initial begin
    test_reset();
    test_perfect();
    test_newer_judge();
    test_game_over();
    test_null_judge();
    test_pwm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
